lsu_req_buf: RTL and testbench

- Parametrised, clocked request buffer between the LSU and the data-memory port.
- Successor to the single-entry, edge-latched LSU output register: DEPTH-entry FIFO, byte enables, flush support.
- LSU side uses req/gnt; memory side uses req/gnt with the Ibex stable-until-grant rule.
- Lets the LSU issue back-to-back requests while memory stalls.

---
 rtl/lsu_buf_pkg.sv | 26 ++
 rtl/lsu_fifo_ctrl.sv | 66 ++++++
 rtl/lsu_req_buf.sv | 105 ++++++++++
 tb/tb_lsu_req_buf.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_buf_pkg.sv
// Shared types and helpers for the LSU request buffer.
package lsu_buf_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned BE_W_DEF   = DATA_W_DEF / 8;

  // One LSU request as seen on either side of the buffer (default widths)
  typedef struct packed {
    logic                  we;
    logic [BE_W_DEF-1:0]   be;
    logic [DATA_W_DEF-1:0] wdata;
    logic [ADDR_W_DEF-1:0] addr;
  } lsu_req_t;

  // Pointer width for a DEPTH-entry ring; never narrower than one bit
  function automatic int unsigned clog2_depth(input int unsigned depth);
    int unsigned w;
    w = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < depth) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/lsu_fifo_ctrl.sv
// Pointer, occupancy and handshake qualification for the LSU request FIFO.
module lsu_fifo_ctrl
  import lsu_buf_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = clog2_depth(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_req_i,
  input  logic             pop_req_i,
  output logic             push_c,
  output logic             pop_c,
  output logic             gnt_c,
  output logic             full_c,
  output logic             empty_c,
  output logic [PTR_W-1:0] wr_ptr_o,
  output logic [PTR_W-1:0] rd_ptr_o,
  output logic [CNT_W-1:0] count_o
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Grant depends only on local state and flush, never on the memory grant
  assign full_c  = (count_q == CNT_W'(DEPTH));
  assign empty_c = (count_q == '0);
  assign gnt_c   = !full_c && !flush_i;
  assign push_c  = push_req_i && gnt_c;
  assign pop_c   = pop_req_i && !empty_c;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign wr_ptr_o = wr_ptr_q;
  assign rd_ptr_o = rd_ptr_q;
  assign count_o  = count_q;

endmodule

// File: rtl/lsu_req_buf.sv
// DEPTH-entry request FIFO between the LSU and the data-memory port.
module lsu_req_buf
  import lsu_buf_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  input  logic                         lsu_req_i,
  output logic                         lsu_gnt_o,
  input  logic                         lsu_we_i,
  input  logic [DATA_W/8-1:0]          lsu_be_i,
  input  logic [DATA_W-1:0]            lsu_wdata_i,
  input  logic [ADDR_W-1:0]            lsu_addr_i,
  output logic                         data_req_o,
  input  logic                         data_gnt_i,
  output logic                         data_we_o,
  output logic [DATA_W/8-1:0]          data_be_o,
  output logic [DATA_W-1:0]            data_wdata_o,
  output logic [ADDR_W-1:0]            data_addr_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         full_o,
  output logic                         empty_o
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned PTR_W = clog2_depth(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) ||
      (DATA_W == 0) || ((DATA_W % 8) != 0)) begin : g_bad_param
    $fatal(1, "lsu_req_buf: DEPTH must be a power of two >= 2, DATA_W a multiple of 8");
  end

  typedef struct packed {
    logic              we;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] wdata;
    logic [ADDR_W-1:0] addr;
  } entry_t;

  logic             push_c;
  logic             pop_c;
  logic             gnt_c;
  logic             full_c;
  logic             empty_c;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  entry_t mem_q [DEPTH];
  entry_t mem_d [DEPTH];
  entry_t wr_entry;
  entry_t head;

  lsu_fifo_ctrl #(
    .DEPTH (DEPTH)
  ) u_ctrl (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .flush_i    (flush_i),
    .push_req_i (lsu_req_i),
    .pop_req_i  (data_gnt_i),
    .push_c     (push_c),
    .pop_c      (pop_c),
    .gnt_c      (gnt_c),
    .full_c     (full_c),
    .empty_c    (empty_c),
    .wr_ptr_o   (wr_ptr),
    .rd_ptr_o   (rd_ptr),
    .count_o    (count)
  );

  assign wr_entry = '{we: lsu_we_i, be: lsu_be_i, wdata: lsu_wdata_i, addr: lsu_addr_i};

  // Writes never land on rd_ptr while occupied, so the head stays stable under stall
  always_comb begin
    mem_d = mem_q;
    if (push_c) mem_d[wr_ptr] = wr_entry;
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  // Head fields are zeroed when nothing is buffered
  always_comb begin
    head = mem_q[rd_ptr];
    if (empty_c) head = '0;
  end

  assign lsu_gnt_o    = gnt_c;
  assign data_req_o   = !empty_c;
  assign data_we_o    = head.we;
  assign data_be_o    = head.be;
  assign data_wdata_o = head.wdata;
  assign data_addr_o  = head.addr;
  assign count_o      = count;
  assign full_o       = full_c;
  assign empty_o      = empty_c;

endmodule

// File: tb/tb_lsu_req_buf.sv
// Directed and randomized checks of lsu_req_buf (DEPTH 2 and 4) against a queue model.
module tb_lsu_req_buf;
  import lsu_buf_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush;
  logic        lsu_req;
  logic        lsu_we;
  logic [3:0]  lsu_be;
  logic [31:0] lsu_wdata;
  logic [31:0] lsu_addr;
  logic        gnt2, gnt4;

  logic        d2_lgnt, d2_req, d2_we, d2_full, d2_empty;
  logic [3:0]  d2_be;
  logic [31:0] d2_wdata, d2_addr;
  logic [1:0]  d2_cnt;
  logic        d4_lgnt, d4_req, d4_we, d4_full, d4_empty;
  logic [3:0]  d4_be;
  logic [31:0] d4_wdata, d4_addr;
  logic [2:0]  d4_cnt;

  always #5 clk_i = ~clk_i;

  lsu_req_buf #(.ADDR_W(32), .DATA_W(32), .DEPTH(2)) u_d2 (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush),
    .lsu_req_i(lsu_req), .lsu_gnt_o(d2_lgnt), .lsu_we_i(lsu_we), .lsu_be_i(lsu_be),
    .lsu_wdata_i(lsu_wdata), .lsu_addr_i(lsu_addr),
    .data_req_o(d2_req), .data_gnt_i(gnt2), .data_we_o(d2_we), .data_be_o(d2_be),
    .data_wdata_o(d2_wdata), .data_addr_o(d2_addr),
    .count_o(d2_cnt), .full_o(d2_full), .empty_o(d2_empty)
  );

  lsu_req_buf #(.ADDR_W(32), .DATA_W(32), .DEPTH(4)) u_d4 (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush),
    .lsu_req_i(lsu_req), .lsu_gnt_o(d4_lgnt), .lsu_we_i(lsu_we), .lsu_be_i(lsu_be),
    .lsu_wdata_i(lsu_wdata), .lsu_addr_i(lsu_addr),
    .data_req_o(d4_req), .data_gnt_i(gnt4), .data_we_o(d4_we), .data_be_o(d4_be),
    .data_wdata_o(d4_wdata), .data_addr_o(d4_addr),
    .count_o(d4_cnt), .full_o(d4_full), .empty_o(d4_empty)
  );

  lsu_req_t    q2[$];
  lsu_req_t    q4[$];
  logic [31:0] seen4[$];
  bit          rec4 = 1'b0;
  int          vecs = 0;
  int          errs = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare one instance's outputs with what its model queue implies
  task automatic chk_side(input string nm, input lsu_req_t q[$], input int depth,
                          input logic lgnt, input logic req, input logic we,
                          input logic [3:0] be, input logic [31:0] wd, input logic [31:0] ad,
                          input logic [31:0] cnt, input logic full, input logic empty);
    lsu_req_t h;
    h = (q.size() > 0) ? q[0] : '0;
    chk({nm, ".lsu_gnt"}, 32'(lgnt), 32'(!flush && (q.size() < depth)));
    chk({nm, ".req"},     32'(req),  32'(q.size() > 0));
    chk({nm, ".we"},      32'(we),   32'(h.we));
    chk({nm, ".be"},      32'(be),   32'(h.be));
    chk({nm, ".wdata"},   wd,        h.wdata);
    chk({nm, ".addr"},    ad,        h.addr);
    chk({nm, ".count"},   cnt,       32'(q.size()));
    chk({nm, ".full"},    32'(full), 32'(q.size() == depth));
    chk({nm, ".empty"},   32'(empty), 32'(q.size() == 0));
  endtask

  // Check, then advance one clock and update both models
  task automatic cycle();
    bit push2, push4, pop2, pop4;
    lsu_req_t cur;
    #1;
    chk_side("d2", q2, 2, d2_lgnt, d2_req, d2_we, d2_be, d2_wdata, d2_addr,
             32'(d2_cnt), d2_full, d2_empty);
    chk_side("d4", q4, 4, d4_lgnt, d4_req, d4_we, d4_be, d4_wdata, d4_addr,
             32'(d4_cnt), d4_full, d4_empty);
    if (rec4 && d4_req && gnt4) seen4.push_back(d4_addr);
    cur   = '{we: lsu_we, be: lsu_be, wdata: lsu_wdata, addr: lsu_addr};
    push2 = lsu_req && !flush && (q2.size() < 2);
    push4 = lsu_req && !flush && (q4.size() < 4);
    pop2  = gnt2 && (q2.size() > 0);
    pop4  = gnt4 && (q4.size() > 0);
    @(posedge clk_i);
    #1;
    if (flush) begin
      q2.delete();
      q4.delete();
    end else begin
      if (pop2)  void'(q2.pop_front());
      if (push2) q2.push_back(cur);
      if (pop4)  void'(q4.pop_front());
      if (push4) q4.push_back(cur);
    end
  endtask

  task automatic set_req(input logic req, input logic we, input logic [3:0] be,
                         input logic [31:0] wd, input logic [31:0] ad);
    lsu_req = req; lsu_we = we; lsu_be = be; lsu_wdata = wd; lsu_addr = ad;
  endtask

  task automatic drain();
    lsu_req = 1'b0; flush = 1'b0; gnt2 = 1'b1; gnt4 = 1'b1;
    for (int c = 0; c < 12 && (q2.size() > 0 || q4.size() > 0); c++) cycle();
    chk("drain.done", 32'(q2.size() + q4.size()), 32'd0);
  endtask

  initial begin
    int i;
    bit acc;
    rst_ni = 1'b0; flush = 1'b0; gnt2 = 1'b0; gnt4 = 1'b0;
    set_req(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

    // Reset state
    #1;
    chk_side("rst2", q2, 2, d2_lgnt, d2_req, d2_we, d2_be, d2_wdata, d2_addr,
             32'(d2_cnt), d2_full, d2_empty);
    chk_side("rst4", q4, 4, d4_lgnt, d4_req, d4_we, d4_be, d4_wdata, d4_addr,
             32'(d4_cnt), d4_full, d4_empty);
    #10 rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Reset mid-traffic with two entries buffered
    set_req(1'b1, 1'b0, 4'hf, 32'h0, 32'h40); cycle();
    set_req(1'b1, 1'b1, 4'h1, 32'h5, 32'h44); cycle();
    lsu_req = 1'b0;
    #1 chk("midrst.pre_cnt", 32'(d4_cnt), 32'd2);
    #1 rst_ni = 1'b0;
    #1;
    chk("midrst.req2", 32'(d2_req), 32'd0);
    chk("midrst.cnt2", 32'(d2_cnt), 32'd0);
    chk("midrst.req4", 32'(d4_req), 32'd0);
    chk("midrst.cnt4", 32'(d4_cnt), 32'd0);
    q2.delete(); q4.delete();
    #2 rst_ni = 1'b1;
    #1 chk("midrst.gnt", 32'(d4_lgnt), 32'd1);
    cycle();

    // Single store, memory always granting
    gnt2 = 1'b1; gnt4 = 1'b1;
    set_req(1'b1, 1'b1, 4'b0011, 32'hDEADBEEF, 32'h1000);
    cycle();
    lsu_req = 1'b0;
    #1;
    chk("st.req",   32'(d2_req), 32'd1);
    chk("st.we",    32'(d2_we),  32'd1);
    chk("st.be",    32'(d2_be),  32'h3);
    chk("st.wdata", d2_wdata,    32'hDEADBEEF);
    chk("st.addr",  d2_addr,     32'h1000);
    cycle();
    chk("st.cnt", 32'(d2_cnt), 32'd0);

    // Backpressure until full, then ordered drain
    gnt2 = 1'b0; gnt4 = 1'b0;
    set_req(1'b1, 1'b0, 4'hf, 32'h0, 32'h10); cycle();
    set_req(1'b1, 1'b0, 4'hf, 32'h0, 32'h14); cycle();
    set_req(1'b1, 1'b0, 4'hf, 32'h0, 32'h18);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp.full",    32'(d2_full), 32'd1);
      chk("bp.lsu_gnt", 32'(d2_lgnt), 32'd0);
      chk("bp.hold",    d2_addr,      32'h10);
      cycle();
    end
    lsu_req = 1'b0; gnt2 = 1'b1;
    #1 chk("bp.ord0", d2_addr, 32'h10);
    cycle();
    #1 chk("bp.ord1", d2_addr, 32'h14);
    cycle();
    drain();

    // Simultaneous push and pop
    gnt2 = 1'b0; gnt4 = 1'b0;
    set_req(1'b1, 1'b0, 4'hf, 32'h0, 32'h20); cycle();
    set_req(1'b1, 1'b0, 4'hf, 32'h0, 32'h24); gnt2 = 1'b1;
    cycle();
    lsu_req = 1'b0; gnt2 = 1'b0;
    #1;
    chk("pp.cnt",  32'(d2_cnt), 32'd1);
    chk("pp.addr", d2_addr,     32'h24);
    drain();

    // Wrap-around on the DEPTH=4 instance under random grant
    seen4.delete(); rec4 = 1'b1; i = 0;
    for (int c = 0; c < 200 && (i < 10 || q4.size() > 0); c++) begin
      if (i < 10) set_req(1'b1, 1'b0, 4'hf, 32'h0, 32'h100 + 32'(4 * i));
      else lsu_req = 1'b0;
      gnt4 = 1'($urandom_range(0, 1)); gnt2 = 1'b1;
      acc = lsu_req && (q4.size() < 4);
      cycle();
      if (acc) i++;
    end
    rec4 = 1'b0;
    chk("wrap.n", 32'(seen4.size()), 32'd10);
    for (int k = 0; k < 10 && k < seen4.size(); k++)
      chk("wrap.addr", seen4[k], 32'h100 + 32'(4 * k));
    drain();

    // Flush with three buffered, a pending LSU request and a head grant
    gnt2 = 1'b0; gnt4 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_req(1'b1, 1'b1, 4'hc, 32'(k), 32'h200 + 32'(4 * k));
      cycle();
    end
    flush = 1'b1; lsu_req = 1'b1; gnt4 = 1'b1;
    #1;
    chk("fl.cnt_pre", 32'(d4_cnt),  32'd3);
    chk("fl.lsu_gnt", 32'(d4_lgnt), 32'd0);
    chk("fl.issued",  32'(d4_req && gnt4), 32'd1);
    chk("fl.head",    d4_addr,      32'h200);
    cycle();
    flush = 1'b0; lsu_req = 1'b0;
    #1;
    chk("fl.cnt", 32'(d4_cnt), 32'd0);
    chk("fl.req", 32'(d4_req), 32'd0);
    cycle();

    // Randomized traffic with occasional flush
    for (int c = 0; c < 400; c++) begin
      set_req(1'($urandom_range(0, 1)), 1'($urandom), 4'($urandom), $urandom, $urandom);
      gnt2  = 1'($urandom_range(0, 1));
      gnt4  = 1'($urandom_range(0, 2) == 0);
      flush = ($urandom_range(0, 19) == 0);
      cycle();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
